// File: rtl/refresh_scanner_if.sv
// Control and display-drive signals of the digit refresh scanner.
// master = the scanner itself, slave = the controller / segment mux side.
interface refresh_scanner_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
);
  logic                  enable;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [IDX_W-1:0]      digit_sel;
  logic [NUM_DIGITS-1:0] anode;
  logic                  slot_tick;
  logic                  frame_done;

  modport master (
    input  enable, digit_mask,
    output digit_sel, anode, slot_tick, frame_done
  );

  modport slave (
    output enable, digit_mask,
    input  digit_sel, anode, slot_tick, frame_done
  );
endinterface

// File: rtl/refresh_scanner.sv
// Seven-segment digit scanner: prescaled slots, dead-time gap before each digit,
// pause, per-digit blanking and selectable anode polarity.
module refresh_scanner #(
  parameter int NUM_DIGITS       = 8,
  parameter int PRESCALE         = 100000,
  parameter int GAP_CYCLES       = 1000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input logic              refresh_clock,
  input logic              reset,
  refresh_scanner_if.master bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] DIG_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    ON   = 2'd2
  } state_e;

  // With no dead time a new slot goes straight to the lit phase.
  localparam state_e START_ST = (GAP_CYCLES > 0) ? GAP : ON;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] digit_sel_q, digit_sel_d;
  logic             slot_tick_q, slot_tick_d;
  logic             frame_done_q, frame_done_d;
  logic [IDX_W-1:0] sel_next;
  logic [NUM_DIGITS-1:0] lit;

  always_ff @(posedge refresh_clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      digit_sel_q  <= '0;
      slot_tick_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_sel_q  <= digit_sel_d;
      slot_tick_q  <= slot_tick_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_sel_d  = digit_sel_q;
    slot_tick_d  = 1'b0;
    frame_done_d = 1'b0;
    sel_next     = (digit_sel_q == DIG_LAST) ? '0 : digit_sel_q + 1'b1;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = START_ST;
          cnt_d       = '0;
          slot_tick_d = 1'b1;
        end
        GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) state_d = ON;
        end
        ON: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            state_d      = START_ST;
            slot_tick_d  = 1'b1;
            digit_sel_d  = sel_next;
            frame_done_d = (sel_next == '0);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Mask is applied live so a blanked digit goes dark in the same cycle.
  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lit[i] = (state_q == ON) && (digit_sel_q == IDX_W'(i)) && bus.digit_mask[i];
    end
  end

  assign bus.anode      = (ANODE_ACTIVE_LOW != 0) ? ~lit : lit;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.slot_tick  = slot_tick_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_refresh_scanner.sv
// Scoreboard bench: two scanner variants (with gap / active-low, and without gap / active-high)
// compared cycle by cycle against a slot-position reference model.
module tb_refresh_scanner;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] mask;

  always #5 clk = ~clk;

  refresh_scanner_if #(.NUM_DIGITS(3)) bus_a ();
  refresh_scanner_if #(.NUM_DIGITS(3)) bus_b ();

  assign bus_a.enable     = enable;
  assign bus_a.digit_mask = mask;
  assign bus_b.enable     = enable;
  assign bus_b.digit_mask = mask;

  refresh_scanner #(.NUM_DIGITS(3), .PRESCALE(4), .GAP_CYCLES(1), .ANODE_ACTIVE_LOW(1)) dut_a (
    .refresh_clock(clk), .reset(rst), .bus(bus_a));
  refresh_scanner #(.NUM_DIGITS(3), .PRESCALE(4), .GAP_CYCLES(0), .ANODE_ACTIVE_LOW(0)) dut_b (
    .refresh_clock(clk), .reset(rst), .bus(bus_b));

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] an;
    logic       tick;
    logic       frame;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   frames_a = 0;
  int   frames_b = 0;

  // Reference model: a slot is PRESCALE cycles long; the digit is lit once the
  // position inside the slot has passed the gap.
  int gap_c[2] = '{1, 0};
  bit act_lo[2] = '{1'b1, 1'b0};
  bit run[2];
  int pos[2];
  int dig[2];
  bit tk[2];
  bit fr[2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run[k] = 1'b0; pos[k] = 0; dig[k] = 0; tk[k] = 1'b0; fr[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit en);
    for (int k = 0; k < 2; k++) begin
      tk[k] = 1'b0;
      fr[k] = 1'b0;
      if (!en) begin
        run[k] = 1'b0;
        pos[k] = 0;
      end else if (!run[k]) begin
        run[k] = 1'b1;
        pos[k] = 0;
        tk[k]  = 1'b1;
      end else if (pos[k] == 3) begin
        pos[k] = 0;
        dig[k] = (dig[k] + 1) % 3;
        tk[k]  = 1'b1;
        fr[k]  = (dig[k] == 0);
      end else begin
        pos[k] = pos[k] + 1;
      end
    end
  endtask

  function automatic obs_t model_out(input int k);
    obs_t       o;
    logic [2:0] on;
    for (int i = 0; i < 3; i++)
      on[i] = run[k] && (pos[k] >= gap_c[k]) && (dig[k] == i) && mask[i];
    o.sel   = 2'(dig[k]);
    o.an    = act_lo[k] ? ~on : on;
    o.tick  = tk[k];
    o.frame = fr[k];
    return o;
  endfunction

  // Monitor: every cycle the DUTs present outputs; compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_digit_sel",  8'(bus_a.digit_sel),  8'(e.a.sel));
        chk("a_anode",      8'(bus_a.anode),      8'(e.a.an));
        chk("a_slot_tick",  8'(bus_a.slot_tick),  8'(e.a.tick));
        chk("a_frame_done", 8'(bus_a.frame_done), 8'(e.a.frame));
        chk("b_digit_sel",  8'(bus_b.digit_sel),  8'(e.b.sel));
        chk("b_anode",      8'(bus_b.anode),      8'(e.b.an));
        chk("b_slot_tick",  8'(bus_b.slot_tick),  8'(e.b.tick));
        chk("b_frame_done", 8'(bus_b.frame_done), 8'(e.b.frame));
        chk("a_onehot", 8'($countones(~bus_a.anode) <= 1), 8'd1);
        chk("b_onehot", 8'($countones(bus_b.anode) <= 1), 8'd1);
        if (bus_a.frame_done === 1'b1) frames_a++;
        if (bus_b.frame_done === 1'b1) frames_b++;
      end
    end
  end

  initial begin
    int pause_st = 0, pause_at = 0;
    int mr_st = 0, mr_at = 0;
    rst    = 1'b1;
    enable = 1'b1;
    mask   = 3'b111;
    model_reset();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else     model_step(enable);

      if (cyc == 2) rst = 1'b0;

      if (cyc < 100) mask = (cyc >= 40 && cyc < 56) ? 3'b101 : 3'b111;

      if (pause_st == 0 && cyc >= 60 && run[0] && dig[0] == 1 && pos[0] == 2) begin
        enable = 1'b0; pause_st = 1; pause_at = cyc;
      end else if (pause_st == 1 && cyc == pause_at + 2) begin
        enable = 1'b1; pause_st = 2;
      end

      if (mr_st == 0 && pause_st == 2 && cyc >= 80 && run[0] && pos[0] >= 2) begin
        rst = 1'b1; mr_st = 1; mr_at = cyc;
        model_reset();
        #1;
        chk("async_rst_a_anode", 8'(bus_a.anode), 8'h07);
        chk("async_rst_a_sel",   8'(bus_a.digit_sel), 8'h00);
        chk("async_rst_b_anode", 8'(bus_b.anode), 8'h00);
      end else if (mr_st == 1 && cyc == mr_at + 1) begin
        rst = 1'b0; mr_st = 2;
      end

      if (cyc >= 100 && mr_st == 2) begin
        mask   = 3'($urandom);
        enable = ($urandom_range(0, 9) != 0);
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          model_reset();
        end
      end

      exp_q.push_back('{a: model_out(0), b: model_out(1)});
    end

    repeat (2) @(negedge clk);
    chk("a_frames_seen", 8'(frames_a > 0), 8'd1);
    chk("b_frames_seen", 8'(frames_b > 0), 8'd1);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
